// File: rtl/inert_serf.sv
// inert_serf: SPI register slave for a yaw-rate gyro front end.
//   The SPI pins are oversampled in clk. Each frame is 16 bits: a R/W bit, a
//   7-bit address and a data byte. Read data is returned in the second byte.
//   A yaw_in sample (qualified by sample_vld) is held for readback: 0x26 gives
//   the low byte and 0x27 the high byte. Reading 0x26 snapshots the high byte,
//   so the pair cannot tear. INT flags new data and is cleared by a completed
//   read of 0x27.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   SS_n, SCLK, MOSI  SPI slave inputs (SCLK idles high, mode 3)
//   MISO              SPI data out, changed on SCLK fall
//   yaw_in, sample_vld  sensor sample and its single-cycle strobe
//   INT               data-ready interrupt (level)
//   gyro_cfg          live copy of CTRL2_G
module inert_serf #(
  parameter logic [7:0]  WHO_AM_I   = 8'h6A,
  parameter int unsigned INT_EN_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] yaw_in,
  input  logic        sample_vld,
  output logic        INT,
  output logic [7:0]  gyro_cfg
);

  localparam logic [2:0] EN_IDX = 3'(INT_EN_BIT);

  typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_q, sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] rx_shft;
  logic [4:0]  rx_cnt;
  logic [7:0]  rd_byte;
  logic        rd_frame;
  logic [7:0]  int1_ctrl, ctrl2_g, ctrl7_g, shadow_h;
  logic [15:0] yaw_hold;
  logic [7:0]  rd_mux;
  logic        ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;
  logic        load_rd, do_commit, full_frame, int_set, int_clr;

  // Stage [1] is the synchronized copy; stage [2] is its previous value and
  // is used only for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign ss_low    = ~ss_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign mosi_sync = mosi_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_rd   = 1'b0;
    do_commit = 1'b0;
    if (state == COMMIT) begin
      do_commit = 1'b1;
      state_nxt = IDLE;
    end else if (ss_rise) begin
      state_nxt = COMMIT;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_nxt = CMD;
        CMD: begin
          if (rx_cnt == 5'd8) begin
            state_nxt = DATA;
            load_rd   = 1'b1;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Register selected by the command byte, which sits in rx_shft[7:0] at rx_cnt = 8.
  always_comb begin
    rd_mux = '0;
    case (rx_shft[6:0])
      7'h0D: rd_mux = int1_ctrl;
      7'h0F: rd_mux = WHO_AM_I;
      7'h11: rd_mux = ctrl2_g;
      7'h14: rd_mux = ctrl7_g;
      7'h26: rd_mux = yaw_hold[7:0];
      7'h27: rd_mux = shadow_h;
      default: rd_mux = '0;
    endcase
  end

  assign full_frame = (rx_cnt == 5'd16);
  assign int_set    = sample_vld && int1_ctrl[EN_IDX] && (ctrl2_g[7:4] != 4'h0);
  assign int_clr    = do_commit && full_frame && rx_shft[15] && (rx_shft[14:8] == 7'h27);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft   <= '0;
      rx_cnt    <= '0;
      rd_byte   <= '0;
      rd_frame  <= 1'b0;
      int1_ctrl <= '0;
      ctrl2_g   <= '0;
      ctrl7_g   <= '0;
      shadow_h  <= '0;
      yaw_hold  <= '0;
      MISO      <= 1'b0;
      INT       <= 1'b0;
    end else begin
      if (state == IDLE && ss_fall) begin
        rx_shft  <= '0;
        rx_cnt   <= '0;
        rd_frame <= 1'b0;
      end else if ((state == CMD || state == DATA) && sclk_rise && ss_low) begin
        rx_shft <= {rx_shft[14:0], mosi_sync};
        if (!full_frame) rx_cnt <= rx_cnt + 5'd1;
      end

      if (load_rd && rx_shft[7]) begin
        rd_byte  <= rd_mux;
        rd_frame <= 1'b1;
        if (rx_shft[6:0] == 7'h26) shadow_h <= yaw_hold[15:8];
      end

      // rx_cnt 8..15 maps to rd_byte bits 7..0, MSB first.
      if (sclk_fall && ss_low) begin
        if (rd_frame && rx_cnt >= 5'd8 && rx_cnt <= 5'd15)
          MISO <= rd_byte[3'd7 - rx_cnt[2:0]];
        else
          MISO <= 1'b0;
      end

      if (do_commit && full_frame && !rx_shft[15]) begin
        case (rx_shft[14:8])
          7'h0D: int1_ctrl <= rx_shft[7:0];
          7'h11: ctrl2_g   <= rx_shft[7:0];
          7'h14: ctrl7_g   <= rx_shft[7:0];
          default: ;
        endcase
      end

      if (sample_vld) yaw_hold <= yaw_in;

      if (int_set)      INT <= 1'b1;
      else if (int_clr) INT <= 1'b0;
    end
  end

  assign gyro_cfg = ctrl2_g;

endmodule
